// File: rtl/aer_spike_encoder.sv
// AER spike encoder: priority-serialises an 8-bit spike vector into a FIFO of address events.
// Define AER_TIMESTAMP_EN to attach a free-running TS_W-bit timestamp to each event.
module aer_spike_encoder #(
  parameter int DEPTH = 8,
  parameter int TS_W  = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [7:0]      spike_in,
  input  logic            spike_valid,
  output logic [2:0]      aer_addr,
  output logic [TS_W-1:0] aer_ts,
  output logic            aer_valid,
  input  logic            aer_ready,
  output logic [7:0]      drop_cnt,
  output logic            ovf,
  input  logic            clr_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
`ifdef AER_TIMESTAMP_EN
  localparam int EW = 3 + TS_W;
`else
  localparam int EW = 3;
`endif

  logic [7:0]    r_pend;
  logic [EW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [CW-1:0] r_cnt;
  logic [7:0]    r_drop;
  logic          r_ovf;

  logic [2:0]    w_sel;
  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic [7:0]    w_clr;
  logic [7:0]    w_lost;
  logic [3:0]    w_nlost;
  logic [8:0]    w_dsum;
  logic [EW-1:0] w_entry;
  logic [EW-1:0] w_head;

  // Descending scan so the lowest set index wins.
  always_comb begin
    w_sel = '0;
    for (int i = 7; i >= 0; i--) begin
      if (r_pend[i]) w_sel = 3'(i);
    end
  end

  assign w_full = (r_cnt == CW'(DEPTH));
  assign w_push = (|r_pend) && !w_full;
  assign w_pop  = (r_cnt != '0) && aer_ready;
  assign w_clr  = w_push ? (8'd1 << w_sel) : 8'd0;

  // A new spike on a still-pending, unserviced bit is lost.
  assign w_lost = spike_valid ? (spike_in & r_pend & ~w_clr) : 8'd0;

  always_comb begin
    w_nlost = '0;
    for (int i = 0; i < 8; i++) begin
      w_nlost = w_nlost + 4'(w_lost[i]);
    end
  end

  assign w_dsum = {1'b0, r_drop} + 9'(w_nlost);

`ifdef AER_TIMESTAMP_EN
  logic [TS_W-1:0] r_ts;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ts <= '0;
    else        r_ts <= r_ts + TS_W'(1);
  end

  assign w_entry = {w_sel, r_ts};
  assign aer_ts  = w_head[TS_W-1:0];
`else
  assign w_entry = w_sel;
  assign aer_ts  = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend <= '0;
    end else if (spike_valid) begin
      r_pend <= (r_pend & ~w_clr) | spike_in;
    end else begin
      r_pend <= r_pend & ~w_clr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wp] <= w_entry;
        r_wp        <= r_wp + AW'(1);
      end
      if (w_pop) r_rp <= r_rp + AW'(1);
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end

  // Clear wins over any drop counted in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop <= '0;
      r_ovf  <= 1'b0;
    end else if (clr_ovf) begin
      r_drop <= '0;
      r_ovf  <= 1'b0;
    end else if (w_nlost != '0) begin
      r_drop <= w_dsum[8] ? 8'hFF : w_dsum[7:0];
      r_ovf  <= 1'b1;
    end
  end

  assign w_head    = r_mem[r_rp];
  assign aer_addr  = w_head[EW-1 -: 3];
  assign aer_valid = (r_cnt != '0);
  assign drop_cnt  = r_drop;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_aer_spike_encoder.sv
// Directed bench for aer_spike_encoder: latency, ordering, back-pressure,
// drop counting/saturation, clear priority and async reset.
module tb_aer_spike_encoder;

  localparam int TS_W = 8;

  logic            clk;
  logic            rst_n;
  logic [7:0]      spike_in;
  logic            spike_valid;
  logic [2:0]      aer_addr;
  logic [TS_W-1:0] aer_ts;
  logic            aer_valid;
  logic            aer_ready;
  logic [7:0]      drop_cnt;
  logic            ovf;
  logic            clr_ovf;

  int n_chk;
  int n_fail;

  aer_spike_encoder #(.DEPTH(8), .TS_W(TS_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .spike_in   (spike_in),
    .spike_valid(spike_valid),
    .aer_addr   (aer_addr),
    .aer_ts     (aer_ts),
    .aer_valid  (aer_valid),
    .aer_ready  (aer_ready),
    .drop_cnt   (drop_cnt),
    .ovf        (ovf),
    .clr_ovf    (clr_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [2:0]      a5_addr [4];
  logic [TS_W-1:0] ts0;

  initial begin
    n_chk  = 0;
    n_fail = 0;
    a5_addr = '{3'd0, 3'd2, 3'd5, 3'd7};
    ts0 = '0;
    rst_n = 1'b0;
    spike_in = '0;
    spike_valid = 1'b0;
    aer_ready = 1'b0;
    clr_ovf = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(aer_valid), 32'd0);
    chk("rst_addr", 32'(aer_addr), 32'd0);
    chk("rst_ts", 32'(aer_ts), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    rst_n = 1'b1;

    // Single spike on bit 0
    aer_ready = 1'b1;
    spike_in = 8'h01;
    spike_valid = 1'b1;
    @(negedge clk);
    spike_valid = 1'b0;
    spike_in = 8'h00;
    chk("t1_lat", 32'(aer_valid), 32'd0);
    @(negedge clk);
    chk("t1_valid", 32'(aer_valid), 32'd1);
    chk("t1_addr", 32'(aer_addr), 32'd0);
    @(negedge clk);
    chk("t1_empty", 32'(aer_valid), 32'd0);
    chk("t1_drop", 32'(drop_cnt), 32'd0);

    // 0xA5 -> 0,2,5,7 back to back
    spike_in = 8'hA5;
    spike_valid = 1'b1;
    @(negedge clk);
    spike_valid = 1'b0;
    spike_in = 8'h00;
    chk("t2_lat", 32'(aer_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t2_valid", 32'(aer_valid), 32'd1);
      chk("t2_addr", 32'(aer_addr), 32'(a5_addr[i]));
`ifdef AER_TIMESTAMP_EN
      if (i == 0) ts0 = aer_ts;
      else chk("t2_ts", 32'(aer_ts), 32'(TS_W'(ts0 + TS_W'(i))));
`else
      chk("t2_ts0", 32'(aer_ts), 32'd0);
`endif
    end
    @(negedge clk);
    chk("t2_empty", 32'(aer_valid), 32'd0);
    chk("t2_drop", 32'(drop_cnt), 32'd0);

    // Re-spike on bit 0 in the cycle it is serviced: two events, no drop
    spike_in = 8'h01;
    spike_valid = 1'b1;
    @(negedge clk);
    chk("t3_lat", 32'(aer_valid), 32'd0);
    @(negedge clk);
    spike_valid = 1'b0;
    spike_in = 8'h00;
    chk("t3_ev0", 32'(aer_valid), 32'd1);
    chk("t3_addr0", 32'(aer_addr), 32'd0);
    @(negedge clk);
    chk("t3_ev1", 32'(aer_valid), 32'd1);
    chk("t3_addr1", 32'(aer_addr), 32'd0);
    chk("t3_drop", 32'(drop_cnt), 32'd0);
    chk("t3_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    chk("t3_empty", 32'(aer_valid), 32'd0);

    // Fill with 0..7 under back-pressure
    aer_ready = 1'b0;
    spike_in = 8'hFF;
    spike_valid = 1'b1;
    @(negedge clk);
    spike_valid = 1'b0;
    spike_in = 8'h00;
    repeat (10) @(negedge clk);
    chk("t4_valid", 32'(aer_valid), 32'd1);
    chk("t4_addr", 32'(aer_addr), 32'd0);
    chk("t4_drop", 32'(drop_cnt), 32'd0);

    // Drain with ready toggling; head holds while ready=0
    for (int i = 0; i < 8; i++) begin
      chk("t5_valid", 32'(aer_valid), 32'd1);
      chk("t5_addr", 32'(aer_addr), 32'(i));
      @(negedge clk);
      chk("t5_hold", 32'(aer_addr), 32'(i));
      aer_ready = 1'b1;
      @(negedge clk);
      aer_ready = 1'b0;
    end
    chk("t5_empty", 32'(aer_valid), 32'd0);

    // Refill, then drop on bit 0 while full and pending
    spike_in = 8'hFF;
    spike_valid = 1'b1;
    @(negedge clk);
    spike_valid = 1'b0;
    spike_in = 8'h00;
    repeat (10) @(negedge clk);
    chk("t6_full_addr", 32'(aer_addr), 32'd0);
    spike_in = 8'h01;
    spike_valid = 1'b1;
    @(negedge clk);
    chk("t6_nodrop", 32'(drop_cnt), 32'd0);
    chk("t6_noovf", 32'(ovf), 32'd0);
    @(negedge clk);
    spike_valid = 1'b0;
    spike_in = 8'h00;
    chk("t6_drop", 32'(drop_cnt), 32'd1);
    chk("t6_ovf", 32'(ovf), 32'd1);

    // Saturation: 1 + 1 on the first edge, then 8 per edge
    spike_in = 8'hFF;
    spike_valid = 1'b1;
    @(negedge clk);
    chk("t7_step", 32'(drop_cnt), 32'd2);
    @(negedge clk);
    chk("t7_step8", 32'(drop_cnt), 32'd10);
    repeat (38) @(negedge clk);
    chk("t7_sat", 32'(drop_cnt), 32'd255);
    chk("t7_ovf", 32'(ovf), 32'd1);
    clr_ovf = 1'b1;
    @(negedge clk);
    chk("t7_clr_drop", 32'(drop_cnt), 32'd0);
    chk("t7_clr_ovf", 32'(ovf), 32'd0);
    clr_ovf = 1'b0;
    spike_valid = 1'b0;
    spike_in = 8'h00;
    @(negedge clk);
    chk("t7_idle", 32'(drop_cnt), 32'd0);
    chk("t7_still_full", 32'(aer_valid), 32'd1);

    // Async reset with five events buffered
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    spike_in = 8'h1F;
    spike_valid = 1'b1;
    @(negedge clk);
    spike_valid = 1'b0;
    spike_in = 8'h00;
    repeat (5) @(negedge clk);
    chk("t8_pre_valid", 32'(aer_valid), 32'd1);
    chk("t8_pre_addr", 32'(aer_addr), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t8_async_valid", 32'(aer_valid), 32'd0);
    chk("t8_async_drop", 32'(drop_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    aer_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t8_no_stale", 32'(aer_valid), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/aer_spike_encoder.md
Name: aer_spike_encoder

Overview:
- Downstream consumer of the 8-neuron time-multiplexed LIF array's 8-bit spike vector.
- Converts each set spike bit into a serial address-event (AER) word: 3-bit neuron address plus optional timestamp.
- Events are buffered in a small FIFO and presented on a valid/ready interface to the off-chip output / uo_out mux.
- Counts spikes lost to back-pressure.

Parameters:
- DEPTH, 8, FIFO entries; power of 2, minimum 2.
- TS_W, 8, timestamp width in bits.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset; asynchronous assert, active-low.
- spike_in  input  8  spike vector from the neuron array; bit i = neuron i.
- spike_valid  input  1  spike_in is sampled on edges where this is 1.
- aer_addr  output  3  neuron index of the FIFO head event.
- aer_ts  output  TS_W  timestamp of the FIFO head event.
- aer_valid  output  1  FIFO non-empty.
- aer_ready  input  1  consumer accepts the head when aer_valid & aer_ready.
- drop_cnt  output  8  saturating count of dropped spikes.
- ovf  output  1  sticky flag: at least one spike dropped.
- clr_ovf  input  1  synchronous clear of ovf and drop_cnt.

Behaviour:
- Reset (async, rst_n=0) clears:
  - pending[7:0], FIFO pointers/count, ts counter: all 0.
  - Outputs: aer_valid=0, aer_addr=0, aer_ts=0, drop_cnt=0, ovf=0.
  - Reset mid-operation discards all pending and buffered events.
- Capture, each edge with spike_valid=1: pending <= (pending & ~clr_mask) | spike_in.
  - clr_mask is the one-hot bit serviced this cycle.
- Service, each edge:
  - sel = lowest-index set bit of pending (priority encoder, bit 0 highest).
  - If pending≠0 and FIFO count<DEPTH: push {sel, ts}; clr_mask = 1<<sel.
  - Otherwise clr_mask = 0.
  - The full test uses the registered count: a pop in the same cycle does not enable a push.
- Drop: for bit i with spike_in[i]=1, spike_valid=1, pending[i]=1 and clr_mask[i]=0, the spike is lost.
  - drop_cnt increments by the number of such bits (0..8) and saturates at 255.
  - ovf <= 1.
  - If clr_mask[i]=1 in the same cycle, the new spike re-sets pending[i]; this is not a drop.
- clr_ovf=1 zeroes drop_cnt and ovf, taking priority over same-cycle increments.
- Timestamp: free-running TS_W counter, +1 every clk, wraps 2^TS_W−1 → 0.
  - Each event records the counter value at its push edge.
- Latency: a spike sampled at edge k is pushed at edge k+1 at the earliest; aer_valid=1 after edge k+1.
  - N simultaneous spikes emit in ascending index order, one per cycle.
- FIFO: show-ahead, with aer_addr/aer_ts driven from the head entry.
  - Pop on aer_valid & aer_ready.
  - Push and pop in the same cycle are both allowed when count<DEPTH.
  - Pop when empty is ignored.
  - Pointers wrap modulo DEPTH.
  - aer_addr/aer_ts hold stable while aer_valid=1 and aer_ready=0.
- spike_valid=0: no capture; servicing of pending bits continues.

Optional Feature:
- AER_TIMESTAMP_EN defined:
  - Timestamp counter is present.
  - FIFO entries are 3+TS_W bits.
  - aer_ts carries the event time.
- AER_TIMESTAMP_EN undefined:
  - No counter.
  - FIFO entries are 3 bits.
  - aer_ts is constant 0.
  - All other behaviour is identical.

Test Plan:
- Reset, then spike_in=8'b0000_0001, valid=1 for one cycle, aer_ready=1 → one event addr=0 after 1 cycle; aer_valid then 0; drop_cnt=0.
- spike_in=8'hA5 for one cycle, aer_ready=1 → events addr 0,2,5,7 on consecutive cycles.
  - With AER_TIMESTAMP_EN: ts values consecutive.
- aer_ready=0; spike_in=8'hFF for one cycle, then 8'h01 one cycle later:
  - DEPTH=8 fills with addr 0..7.
  - Second spike on bit 0 re-sets pending (bit 0 was cleared when serviced), so drop_cnt=0.
  - Then spike_in=8'h01 again while FIFO is full and pending[0]=1 → drop_cnt=1, ovf=1.
- FIFO full, aer_ready toggled 1/0 → head holds when ready=0; 8 pops deliver addr 0..7 in order; aer_valid falls after the last pop.
- Saturation: FIFO full, pending=8'hFF, spike_in=8'hFF for 40 cycles → drop_cnt=255, ovf=1; clr_ovf=1 → both 0 next cycle.
- Async reset asserted mid-burst (FIFO count 5) → aer_valid=0 immediately; after release no stale events emitted.
